// File: rtl/uart_arb_pkg.sv
// Shared state encoding and configuration defaults for the two-requester UART TX arbiter.
package uart_arb_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  localparam int DEF_TIMEOUT_CYCLES = 1024;
  localparam int STALL_W            = 16;
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Byte handshake bundle between two requesters, the arbiter and the UART transmitter.
interface uart_tx_arbiter_if;
  logic       req0_valid;
  logic [7:0] req0_data;
  logic       req0_last;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic       req1_last;
  logic       req1_ready;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       busy_o;
  logic       timeout_o;

  // master: requesters + transmitter side; slave: the arbiter
  modport master (
    output req0_valid, req0_data, req0_last, req1_valid, req1_data, req1_last, tx_ready,
    input  req0_ready, req1_ready, tx_valid, tx_data, busy_o, timeout_o
  );
  modport slave (
    input  req0_valid, req0_data, req0_last, req1_valid, req1_data, req1_last, tx_ready,
    output req0_ready, req1_ready, tx_valid, tx_data, busy_o, timeout_o
  );
endinterface

// File: rtl/uart_arb_stall_cnt.sv
// Idle-stall counter for a held grant; o_hit flags the last stall cycle before forced release.
module uart_arb_stall_cnt
  import uart_arb_pkg::*;
#(
  parameter int LIMIT = DEF_TIMEOUT_CYCLES
) (
  input  logic clk_i,
  input  logic reset_n,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_hit
);
  logic [STALL_W-1:0] r_cnt;

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n)   r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_inc) r_cnt <= r_cnt + 1'b1;
  end

  assign o_hit = (r_cnt == STALL_W'(LIMIT - 1));
endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-atomic arbiter of two byte requesters onto one UART transmitter.
// Optional grant timeout: define UART_TX_ARBITER_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       clk_i,
  input  logic       reset_n,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  input  logic       tx_ready,
  output logic       busy_o,
  output logic       timeout_o
);
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_tmo
    $error("uart_tx_arbiter: TIMEOUT_CYCLES must be in 2..65535");
  end

  arb_state_t       r_state, w_nstate;
  logic             r_last_grant, w_nlast;
  logic [1:0]       w_vld, w_last;
  logic [1:0][7:0]  w_dat;
  logic             w_busy, w_own, w_xfer, w_tmo;

  assign w_vld  = {req1_valid, req0_valid};
  assign w_last = {req1_last, req0_last};
  assign w_dat  = {req1_data, req0_data};
  assign w_busy = (r_state == GNT0) || (r_state == GNT1);
  assign w_own  = (r_state == GNT1);
  assign busy_o = w_busy;

  // Output mux: the granted requester sees the transmitter directly.
  always_comb begin
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (w_busy) begin
      tx_valid   = w_vld[w_own];
      tx_data    = w_dat[w_own];
      req0_ready = tx_ready & ~w_own;
      req1_ready = tx_ready &  w_own;
    end
  end

  assign w_xfer = tx_valid & tx_ready;

  always_comb begin
    w_nstate = r_state;
    w_nlast  = r_last_grant;
    unique case (r_state)
      IDLE: begin
        if (w_vld == 2'b11)  w_nstate = r_last_grant ? GNT0 : GNT1;
        else if (w_vld[0])   w_nstate = GNT0;
        else if (w_vld[1])   w_nstate = GNT1;
      end
      GNT0, GNT1: begin
        if ((w_xfer && w_last[w_own]) || w_tmo) begin
          w_nstate = IDLE;
          w_nlast  = w_own;
        end
      end
      default: w_nstate = IDLE;
    endcase
  end

  // last_grant resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
    end else begin
      r_state      <= w_nstate;
      r_last_grant <= w_nlast;
    end
  end

`ifdef UART_TX_ARBITER_TIMEOUT_EN
  logic w_stall, w_hit, r_timeout;

  assign w_stall = w_busy & ~w_vld[w_own];

  uart_arb_stall_cnt #(.LIMIT(TIMEOUT_CYCLES)) u_stall (
    .clk_i   (clk_i),
    .reset_n (reset_n),
    .i_clr   (~w_busy | w_xfer),
    .i_inc   (w_stall),
    .o_hit   (w_hit)
  );

  assign w_tmo = w_stall & w_hit;

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) r_timeout <= 1'b0;
    else          r_timeout <= w_tmo;
  end

  assign timeout_o = r_timeout;
`else
  assign w_tmo     = 1'b0;
  assign timeout_o = 1'b0;
`endif
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: vector table, directed corner sequences and a randomized run
// against a cycle-level reference of the arbitration rules.
module tb_uart_tx_arbiter;
  localparam int TB_TMO = 8;

  logic clk_i   = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_errs   = 0;

  uart_tx_arbiter_if bus();

  uart_tx_arbiter #(.TIMEOUT_CYCLES(TB_TMO)) dut (
    .clk_i      (clk_i),
    .reset_n    (reset_n),
    .req0_valid (bus.req0_valid),
    .req0_data  (bus.req0_data),
    .req0_last  (bus.req0_last),
    .req0_ready (bus.req0_ready),
    .req1_valid (bus.req1_valid),
    .req1_data  (bus.req1_data),
    .req1_last  (bus.req1_last),
    .req1_ready (bus.req1_ready),
    .tx_valid   (bus.tx_valid),
    .tx_data    (bus.tx_data),
    .tx_ready   (bus.tx_ready),
    .busy_o     (bus.busy_o),
    .timeout_o  (bus.timeout_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       rst;
    logic       v0; logic [7:0] d0; logic l0;
    logic       v1; logic [7:0] d1; logic l1;
    logic       rdy;
    logic       e_tv; logic [7:0] e_td; logic e_r0; logic e_r1; logic e_busy;
  } vec_t;

  vec_t tbl [11];

  // reference: owner -1 = nobody holds the transmitter
  int   m_own, m_lg, m_stall;
  logic m_tmo;

  task automatic chk1(string nm, logic act, logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %b, expected %b", nm, act, exp);
    end
  endtask

  task automatic chk8(string nm, logic [7:0] act, logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic chki(string nm, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errs++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_in(logic v0, logic [7:0] d0, logic l0,
                        logic v1, logic [7:0] d1, logic l1, logic rdy);
    bus.req0_valid = v0; bus.req0_data = d0; bus.req0_last = l0;
    bus.req1_valid = v1; bus.req1_data = d1; bus.req1_last = l1;
    bus.tx_ready   = rdy;
  endtask

  task automatic chk_idle(string pfx);
    chk1({pfx, ".tx_valid"},   bus.tx_valid,   1'b0);
    chk8({pfx, ".tx_data"},    bus.tx_data,    8'h00);
    chk1({pfx, ".req0_ready"}, bus.req0_ready, 1'b0);
    chk1({pfx, ".req1_ready"}, bus.req1_ready, 1'b0);
    chk1({pfx, ".busy_o"},     bus.busy_o,     1'b0);
  endtask

  task automatic do_reset(string pfx);
    @(negedge clk_i);
    reset_n = 1'b0;
    set_in(0, 8'h00, 0, 0, 8'h00, 0, 0);
    #1;
    chk_idle(pfx);
    chk1({pfx, ".timeout_o"}, bus.timeout_o, 1'b0);
    @(negedge clk_i);
    reset_n = 1'b1;
  endtask

  // Applies the upcoming clock edge to the reference, using the inputs now on the bus.
  task automatic model_step();
    logic [1:0] v, l;
    logic       nt;
    v  = {bus.req1_valid, bus.req0_valid};
    l  = {bus.req1_last,  bus.req0_last};
    nt = 1'b0;
    if (m_own < 0) begin
      m_stall = 0;
      if (v == 2'b11)  m_own = (m_lg == 1) ? 0 : 1;
      else if (v[0])   m_own = 0;
      else if (v[1])   m_own = 1;
    end else if (v[m_own] && bus.tx_ready) begin
      m_stall = 0;
      if (l[m_own]) begin m_lg = m_own; m_own = -1; end
    end else if (!v[m_own]) begin
`ifdef UART_TX_ARBITER_TIMEOUT_EN
      if (m_stall == TB_TMO - 1) begin
        nt = 1'b1; m_lg = m_own; m_own = -1;
      end else begin
        m_stall++;
      end
`endif
    end
    m_tmo = nt;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time bound");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] msg [4];
    int         idx, n;
    logic       tgl, ev, er0, er1, eb;
    logic [7:0] ed;

    msg[0] = 8'h71; msg[1] = 8'h72; msg[2] = 8'h73; msg[3] = 8'h74;
    set_in(0, 8'h00, 0, 0, 8'h00, 0, 0);

    tbl[0]  = '{0, 1,8'h41,0, 0,8'h00,0, 1, 0,8'h00,0,0,0};
    tbl[1]  = '{0, 1,8'h41,0, 0,8'h00,0, 1, 1,8'h41,1,0,1};
    tbl[2]  = '{0, 1,8'h42,0, 0,8'h00,0, 1, 1,8'h42,1,0,1};
    tbl[3]  = '{0, 1,8'h43,1, 0,8'h00,0, 1, 1,8'h43,1,0,1};
    tbl[4]  = '{0, 0,8'h00,0, 0,8'h00,0, 1, 0,8'h00,0,0,0};
    tbl[5]  = '{1, 1,8'hA0,0, 1,8'hB0,0, 1, 0,8'h00,0,0,0};
    tbl[6]  = '{0, 1,8'hA0,0, 1,8'hB0,0, 1, 0,8'h00,0,0,0};
    tbl[7]  = '{0, 1,8'hA1,1, 1,8'hB0,0, 1, 1,8'hA1,1,0,1};
    tbl[8]  = '{0, 0,8'h00,0, 1,8'hB0,0, 1, 0,8'h00,0,0,0};
    tbl[9]  = '{0, 0,8'h00,0, 1,8'hB1,1, 1, 1,8'hB1,0,1,1};
    tbl[10] = '{0, 0,8'h00,0, 0,8'h00,0, 1, 0,8'h00,0,0,0};

    do_reset("por");

    // single message, then tie after reset with grant handover two cycles later
    for (int i = 0; i < 11; i++) begin
      @(negedge clk_i);
      reset_n = ~tbl[i].rst;
      set_in(tbl[i].v0, tbl[i].d0, tbl[i].l0, tbl[i].v1, tbl[i].d1, tbl[i].l1, tbl[i].rdy);
      #1;
      chk1($sformatf("tbl[%0d].tx_valid", i),   bus.tx_valid,   tbl[i].e_tv);
      chk8($sformatf("tbl[%0d].tx_data", i),    bus.tx_data,    tbl[i].e_td);
      chk1($sformatf("tbl[%0d].req0_ready", i), bus.req0_ready, tbl[i].e_r0);
      chk1($sformatf("tbl[%0d].req1_ready", i), bus.req1_ready, tbl[i].e_r1);
      chk1($sformatf("tbl[%0d].busy_o", i),     bus.busy_o,     tbl[i].e_busy);
    end

    // req1 waits out req0's 4-byte message under a toggling tx_ready
    do_reset("s36.rst");
    @(negedge clk_i);
    set_in(1, msg[0], 0, 1, 8'hB0, 0, 1);
    #1; chk1("s36.idle.busy_o", bus.busy_o, 1'b0);
    idx = 0; tgl = 1'b1; n = 0;
    while (idx < 4 && n < 20) begin
      @(negedge clk_i);
      set_in(1, msg[idx], (idx == 3), 1, 8'hB0, 0, tgl);
      #1;
      chk1("s36.req1_ready", bus.req1_ready, 1'b0);
      chk1("s36.req0_ready", bus.req0_ready, tgl);
      chk8("s36.tx_data",    bus.tx_data,    msg[idx]);
      if (tgl) idx++;
      tgl = ~tgl;
      n++;
    end
    chki("s36.bytes_sent", idx, 4);
    @(negedge clk_i);
    set_in(0, 8'h00, 0, 1, 8'hB0, 1, 1);
    #1; chk1("s36.gap.busy_o", bus.busy_o, 1'b0);
    @(negedge clk_i);
    #1;
    chk8("s36.req1.tx_data",    bus.tx_data,    8'hB0);
    chk1("s36.req1.req1_ready", bus.req1_ready, 1'b1);

    // reset mid-message restores req0 priority
    do_reset("s37.rst");
    @(negedge clk_i); set_in(1, 8'h11, 1, 0, 8'h00, 0, 1);
    @(negedge clk_i); #1;
    chk8("s37.first.tx_data", bus.tx_data, 8'h11);
    @(negedge clk_i); set_in(1, 8'h21, 0, 0, 8'h00, 0, 1);
    @(negedge clk_i); set_in(1, 8'h22, 0, 0, 8'h00, 0, 1);
    #1; chk1("s37.mid.busy_o", bus.busy_o, 1'b1);
    #2; reset_n = 1'b0;
    #1; chk_idle("s37.async");
    @(negedge clk_i);
    reset_n = 1'b1;
    set_in(1, 8'h31, 0, 1, 8'h41, 0, 1);
    #1; chk1("s37.post.busy_o", bus.busy_o, 1'b0);
    @(negedge clk_i); #1;
    chk8("s37.post.tx_data",    bus.tx_data,    8'h31);
    chk1("s37.post.req0_ready", bus.req0_ready, 1'b1);
    chk1("s37.post.req1_ready", bus.req1_ready, 1'b0);

    // stall with the grant held by a silent req0
    do_reset("stall.rst");
    @(negedge clk_i); set_in(1, 8'h51, 0, 0, 8'h00, 0, 1);
    @(negedge clk_i); #1;
    chk8("stall.byte.tx_data", bus.tx_data, 8'h51);
`ifdef UART_TX_ARBITER_TIMEOUT_EN
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_i);
      set_in(0, 8'h00, 0, 1, 8'h61, 0, 1);
      #1;
      chk1($sformatf("tmo[%0d].timeout_o", k), bus.timeout_o, (k == 8));
      chk1($sformatf("tmo[%0d].busy_o", k),    bus.busy_o,    (k != 8));
      chk1($sformatf("tmo[%0d].req1_ready", k), bus.req1_ready, (k == 9));
    end
    chk8("tmo.req1.tx_data", bus.tx_data, 8'h61);
`else
    for (int k = 0; k < 100; k++) begin
      @(negedge clk_i);
      set_in(0, 8'h00, 0, 1, 8'h61, 0, 1);
      #1;
      chk1($sformatf("hold[%0d].timeout_o", k),  bus.timeout_o,  1'b0);
      chk1($sformatf("hold[%0d].busy_o", k),     bus.busy_o,     1'b1);
      chk1($sformatf("hold[%0d].req1_ready", k), bus.req1_ready, 1'b0);
    end
`endif

    // randomized traffic against the reference
    do_reset("rnd.rst");
    m_own = -1; m_lg = 1; m_stall = 0; m_tmo = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_i);
      set_in(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 2) != 0));
      #1;
      ev = 1'b0; ed = 8'h00; er0 = 1'b0; er1 = 1'b0; eb = (m_own >= 0);
      if (m_own == 0) begin ev = bus.req0_valid; ed = bus.req0_data; er0 = bus.tx_ready; end
      if (m_own == 1) begin ev = bus.req1_valid; ed = bus.req1_data; er1 = bus.tx_ready; end
      chk1("rnd.tx_valid",   bus.tx_valid,   ev);
      chk8("rnd.tx_data",    bus.tx_data,    ed);
      chk1("rnd.req0_ready", bus.req0_ready, er0);
      chk1("rnd.req1_ready", bus.req1_ready, er1);
      chk1("rnd.busy_o",     bus.busy_o,     eb);
      chk1("rnd.timeout_o",  bus.timeout_o,  m_tmo);
      model_step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 1024, giving the idle-stall cycles before a grant is revoked; legal range 2..65535.
REQ-002 The block SHALL have port clk_i  input  1  platform clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have ports req0_valid/req1_valid  input  1  requester has a byte.
REQ-005 The block SHALL have ports req0_data/req1_data  input  8  requester byte.
REQ-006 The block SHALL have ports req0_last/req1_last  input  1  byte ends the requester's message.
REQ-007 The block SHALL have ports req0_ready/req1_ready  output  1  byte accepted this cycle.
REQ-008 The block SHALL have ports tx_valid  output  1, tx_data  output  8, and tx_ready  input  1; together these form the UART transmitter byte handshake.
REQ-009 The block SHALL have port busy_o  output  1  high while a grant is held.
REQ-010 The block SHALL have port timeout_o  output  1  one-cycle pulse on a forced release.

Function
REQ-011 The FSM SHALL have three states: IDLE, GNT0 and GNT1.
REQ-012 In IDLE, with any reqN_valid high, the FSM SHALL move next cycle to the GNT state of the winner; arbitration latency is exactly 1 cycle.
REQ-013 When both requesters are valid in IDLE, the winner SHALL be the requester not recorded in last_grant (round-robin).
REQ-014 In GNTn, the block SHALL drive tx_valid=reqn_valid and tx_data=reqn_data combinationally, with zero added latency.
REQ-015 In GNTn, reqn_ready SHALL equal tx_ready, and the other requester's ready SHALL be 0.
REQ-016 A transfer SHALL be defined as tx_valid & tx_ready.
REQ-017 A transfer with reqn_last=1 SHALL return the FSM to IDLE next cycle and set last_grant=n.
REQ-018 Messages SHALL never interleave: no byte of the other requester passes while a grant is held.
REQ-019 In IDLE, tx_valid and both readys SHALL be 0, and tx_data SHALL be 8'h00.
REQ-020 busy_o SHALL be 1 exactly in GNT0 and GNT1.
REQ-021 A requester dropping valid mid-message SHALL keep the grant; without ARB_TIMEOUT_EN the grant is held indefinitely.
REQ-022 Going from last-transfer to IDLE and then to a new grant SHALL take a minimum of 2 cycles between messages; back-to-back grant without IDLE is not permitted.

Reset
REQ-023 Asserting reset_n low SHALL immediately force: state=IDLE, last_grant=1 (so req0 wins first), stall counter=0, and all outputs 0.
REQ-024 Reset mid-message SHALL abandon the message; there is no replay.
REQ-025 After reset_n deasserts, the first arbitration SHALL occur on the next clk_i edge with a valid request.

Configuration
REQ-026 Macro UART_TX_ARBITER_TIMEOUT_EN, when defined, SHALL add a 16-bit stall counter.
REQ-027 With the macro defined, the counter SHALL clear on entering GNTn or on any transfer.
REQ-028 With the macro defined, the counter SHALL increment each GNTn cycle in which reqn_valid=0.
REQ-029 With the macro defined, when the counter reaches TIMEOUT_CYCLES-1 the FSM SHALL go to IDLE next cycle, set last_grant=n, and pulse timeout_o for 1 cycle.
REQ-030 With the macro undefined, no counter SHALL exist and timeout_o SHALL be tied 0.

Structure
REQ-031 Package uart_arb_pkg SHALL hold the state encoding constants (IDLE=2'd0, GNT0=2'd1, GNT1=2'd2) and the default TIMEOUT_CYCLES.
REQ-032 The stall counter SHALL be the single sub-module uart_arb_stall_cnt, instantiated only under the macro.
REQ-033 The output mux SHALL stay in the top module.

Verification
REQ-034 Bench SHALL cover reset then req0 sending 3 bytes 8'h41,8'h42,8'h43 with last on 8'h43 and tx_ready=1 -> tx_data sequence 41,42,43, busy_o high 3 cycles, then IDLE.
REQ-035 Bench SHALL cover both requesters valid in IDLE after reset -> GNT0 first; after req0's last, GNT1 granted 2 cycles later.
REQ-036 Bench SHALL cover req1 sending during req0's 4-byte message with tx_ready toggling 1,0,1,... -> req1_ready=0 throughout and no req1 byte on tx_data until req0's last transfers.
REQ-037 Bench SHALL cover reset_n pulsed low mid-message -> all outputs 0 asynchronously, state IDLE, and req0 granted first afterwards.
REQ-038 Bench SHALL cover, with the macro defined and TIMEOUT_CYCLES=8, req0 granted then valid low -> timeout_o pulses 8 cycles after the stall begins and req1 is then granted.
REQ-039 Bench SHALL cover the macro undefined with the same stall for 100 cycles -> grant held and timeout_o=0.
